// File: rtl/hdmi_packet_scheduler.sv
// Data-island slot scheduler: picks GCP/ACR/audio/InfoFrame/null per packet slot, 1-cycle registered result.
// SPD InfoFrame support is compiled in only when HDMI_SCHED_SPD_EN is defined.
module hdmi_packet_scheduler #(
    parameter int ACR_INTERVAL     = 74250,
    parameter int SPD_FRAME_PERIOD = 8,
    parameter int AUDIO_BURST_MAX  = 4
) (
    input  logic       clk_pixel,
    input  logic       reset,
    input  logic       video_field_end,
    input  logic       packet_enable,
    input  logic       audio_req,
    output logic       audio_grant,
    output logic [2:0] pkt_type,
    output logic       pkt_strobe,
    output logic       acr_missed,
    output logic       gcp_missed
);

    localparam logic [2:0]  T_NULL = 3'd0;
    localparam logic [2:0]  T_ACR  = 3'd1;
    localparam logic [2:0]  T_AUD  = 3'd2;
    localparam logic [2:0]  T_GCP  = 3'd3;
    localparam logic [2:0]  T_AVI  = 3'd4;
    localparam logic [2:0]  T_AIF  = 3'd5;
    localparam logic [2:0]  T_SPD  = 3'd6;
    localparam logic [19:0] ACR_LAST  = 20'(ACR_INTERVAL - 1);
    localparam logic [3:0]  BURST_MAX = 4'(AUDIO_BURST_MAX);

    logic [19:0] r_acr_cnt;
    logic [3:0]  r_burst;
    logic        r_gcp_p, r_acr_p, r_avi_p, r_aif_p;
    logic [2:0]  r_pkt_type;
    logic        r_pkt_strobe, r_audio_grant, r_acr_missed, r_gcp_missed;

    logic        w_spd_pend;
    logic        w_acr_wrap;
    logic        w_if_pend;
    logic        w_aud_ok;
    logic [2:0]  w_sel;
    logic        w_grant_gcp, w_grant_acr, w_grant_avi, w_grant_aif;

    assign w_acr_wrap = (r_acr_cnt == ACR_LAST);
    assign w_if_pend  = r_avi_p | r_aif_p | w_spd_pend;
    // Audio yields one slot once a full burst has gone out while an InfoFrame waits.
    assign w_aud_ok   = audio_req & ~((r_burst >= BURST_MAX) & w_if_pend);

    always_comb begin
        w_sel = T_NULL;
        if (r_gcp_p)         w_sel = T_GCP;
        else if (r_acr_p)    w_sel = T_ACR;
        else if (w_aud_ok)   w_sel = T_AUD;
        else if (r_avi_p)    w_sel = T_AVI;
        else if (r_aif_p)    w_sel = T_AIF;
        else if (w_spd_pend) w_sel = T_SPD;
    end

    assign w_grant_gcp = packet_enable & (w_sel == T_GCP);
    assign w_grant_acr = packet_enable & (w_sel == T_ACR);
    assign w_grant_avi = packet_enable & (w_sel == T_AVI);
    assign w_grant_aif = packet_enable & (w_sel == T_AIF);

    // Set terms are OR-ed after the clear so a same-cycle set always wins.
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_acr_cnt     <= '0;
            r_burst       <= '0;
            r_gcp_p       <= 1'b0;
            r_acr_p       <= 1'b0;
            r_avi_p       <= 1'b0;
            r_aif_p       <= 1'b0;
            r_pkt_type    <= T_NULL;
            r_pkt_strobe  <= 1'b0;
            r_audio_grant <= 1'b0;
            r_acr_missed  <= 1'b0;
            r_gcp_missed  <= 1'b0;
        end else begin
            r_acr_cnt     <= w_acr_wrap ? 20'd0 : r_acr_cnt + 20'd1;
            r_pkt_strobe  <= packet_enable;
            r_audio_grant <= packet_enable & (w_sel == T_AUD);
            if (packet_enable) begin
                r_pkt_type <= w_sel;
                if (w_sel != T_AUD)
                    r_burst <= 4'd0;
                else if (r_burst < BURST_MAX)
                    r_burst <= r_burst + 4'd1;
            end
            r_gcp_p <= video_field_end | (r_gcp_p & ~w_grant_gcp);
            r_avi_p <= video_field_end | (r_avi_p & ~w_grant_avi);
            r_aif_p <= video_field_end | (r_aif_p & ~w_grant_aif);
            r_acr_p <= w_acr_wrap      | (r_acr_p & ~w_grant_acr);
            if (video_field_end & r_gcp_p & ~w_grant_gcp)
                r_gcp_missed <= 1'b1;
            if (w_acr_wrap & r_acr_p & ~w_grant_acr)
                r_acr_missed <= 1'b1;
        end
    end

`ifdef HDMI_SCHED_SPD_EN
    localparam logic [7:0] SPD_LAST = 8'(SPD_FRAME_PERIOD - 1);

    logic [7:0] r_frame_cnt;
    logic       r_spd_p;
    logic       w_frame_wrap;
    logic       w_grant_spd;

    assign w_frame_wrap = video_field_end & (r_frame_cnt == SPD_LAST);
    assign w_grant_spd  = packet_enable & (w_sel == T_SPD);
    assign w_spd_pend   = r_spd_p;

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_spd_p     <= 1'b0;
        end else begin
            if (video_field_end)
                r_frame_cnt <= w_frame_wrap ? 8'd0 : r_frame_cnt + 8'd1;
            r_spd_p <= w_frame_wrap | (r_spd_p & ~w_grant_spd);
        end
    end
`else
    assign w_spd_pend = 1'b0;
`endif

    assign pkt_type    = r_pkt_type;
    assign pkt_strobe  = r_pkt_strobe;
    assign audio_grant = r_audio_grant;
    assign acr_missed  = r_acr_missed;
    assign gcp_missed  = r_gcp_missed;

endmodule

// File: doc/hdmi_packet_scheduler.md
# hdmi_packet_scheduler

Data-island slot scheduler for the HDMI transmit path. On every packet slot start (`packet_enable`), it picks which packet type the packet builder emits: GCP, ACR, audio sample, AVI/audio/SPD InfoFrame or null. It tracks per-frame and per-interval obligations as pending flags and grants the audio FIFO with bounded starvation of InfoFrames. It sits between the frame timing logic and the packet builder/assembler in the `clk_pixel` domain.

## Interface
Parameters:
- `ACR_INTERVAL`, 74250: `clk_pixel` cycles between ACR packet requests; range 2..2^20-1.
- `SPD_FRAME_PERIOD`, 8: SPD InfoFrame is requested every N video fields; range 1..255.
- `AUDIO_BURST_MAX`, 4: maximum consecutive audio grants while any InfoFrame is pending; range 1..15.

Ports:
- `clk_pixel`  in  1  pixel clock.
- `reset`  in  1  synchronous, active-high.
- `video_field_end`  in  1  one-cycle pulse at the last active pixel of a field.
- `packet_enable`  in  1  one-cycle pulse at each data-island packet slot start.
- `audio_req`  in  1  level; audio sample FIFO holds at least one packet's worth of samples.
- `audio_grant`  out  1  one-cycle pulse; the FIFO pops one packet.
- `pkt_type`  out  3  0 null, 1 ACR, 2 audio sample, 3 GCP, 4 AVI, 5 audio InfoFrame, 6 SPD; holds between strobes.
- `pkt_strobe`  out  1  one-cycle pulse; `pkt_type` is newly valid.
- `acr_missed`  out  1  sticky; ACR interval expired while ACR was still pending.
- `gcp_missed`  out  1  sticky; field ended while GCP was still pending.

## Operation
- Pending flags: `gcp_p`, `acr_p`, `avi_p`, `aif_p`, `spd_p`. All flags clear on reset.
- On `video_field_end`:
  - Set `gcp_p`, `avi_p` and `aif_p`.
  - Increment the frame counter, which runs 0..SPD_FRAME_PERIOD-1 and wraps. Set `spd_p` when the counter wraps to 0.
  - If `gcp_p` is already 1 and is not being granted this cycle, set `gcp_missed`.
- ACR counter: 20 bits, counts every cycle over 0..ACR_INTERVAL-1. On the wrap to 0, set `acr_p`. If `acr_p` is 1 and is not being granted in that cycle, set `acr_missed`.
- Slot arbitration on `packet_enable` uses the flag values from before this cycle. Priority, highest first:
  1. GCP
  2. ACR
  3. Audio (if `audio_req`=1 and not starved)
  4. AVI
  5. AIF
  6. SPD
  7. Null
- Starvation rule:
  - A 4-bit burst counter increments on each audio grant and clears on any non-audio grant.
  - When the counter reaches AUDIO_BURST_MAX and any of `avi_p`/`aif_p`/`spd_p` is 1, audio is skipped for that slot.
  - If no InfoFrame is pending, the counter saturates and audio continues.
- A grant clears the winning flag. If a set and a clear of the same flag occur in the same cycle, the set wins: the flag stays 1 and no missed flag is raised.
- Audio grant: `audio_grant` pulses together with `pkt_strobe` when type 2 is chosen.
- `packet_enable` with no pending flag and `audio_req`=0 produces `pkt_type`=0 with a strobe.

## Timing
- Latency: `pkt_type`, `pkt_strobe` and `audio_grant` are registered and appear exactly 1 cycle after `packet_enable`.
- Back-to-back `packet_enable` pulses on consecutive cycles are each arbitrated. Pending state updates every cycle.
- Reset values:
  - `pkt_type`=0, `pkt_strobe`=0, `audio_grant`=0, `acr_missed`=0, `gcp_missed`=0.
  - All counters and pending flags 0.
- Reset mid-operation: all state returns to reset values on the next edge. Any strobe scheduled for that edge is suppressed.
- `audio_req` is sampled only in the `packet_enable` cycle.
- Sticky flags clear only on reset.

## Configuration
- `HDMI_SCHED_SPD_EN`:
  - Defined: SPD logic is compiled in. This includes the frame counter and `spd_p`, and type 6 can be emitted.
  - Undefined: the frame counter and `spd_p` are removed, type 6 never appears, and the starvation rule considers only `avi_p`/`aif_p`. `SPD_FRAME_PERIOD` is ignored.

## Test plan
- Reset, then 3 `packet_enable` pulses with no other stimulus and `audio_req`=0 -> three strobes, all `pkt_type`=0, `audio_grant` never asserted.
- `video_field_end` pulse, then 4 slots with `audio_req`=0 -> types 3, 4, 5, 0 in order. With SPD_FRAME_PERIOD=1 and `HDMI_SCHED_SPD_EN` defined -> 3, 4, 5, 6.
- ACR_INTERVAL=100, slots every 40 cycles -> type 1 at the first slot after cycle 99. With no slots for 250 cycles -> `acr_missed`=1.
- AUDIO_BURST_MAX=4, `audio_req` held 1, one `video_field_end`, then 10 slots -> 3, 2, 2, 2, 2, 4, 2, 2, 2, 2. `audio_grant` pulses 8 times.
- `video_field_end` and `packet_enable` in the same cycle with `gcp_p`=1 -> type 3 granted, `gcp_p` remains 1, `gcp_missed` stays 0.
- Assert `reset` in the `packet_enable` cycle -> no strobe, all outputs 0 on the next cycle.
